pong_vga_engine: RTL and testbench



---
 rtl/pong_vga_engine.sv | 172 +++++++++++++++++
 tb/tb_pong_vga_engine.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_vga_engine.sv
// VGA video engine for Pong.
// Divides the system clock down to the pixel rate and runs the raster counters.
// It renders the ball, the two paddles and the dashed centre net from positions
// captured once per frame, so they cannot tear mid-frame. All outputs are
// registered.
module pong_vga_engine #(
   parameter int CLK_DIV       = 4,
   parameter int H_ACTIVE      = 640,
   parameter int H_FP          = 16,
   parameter int H_SYNC        = 96,
   parameter int H_BP          = 48,
   parameter int V_ACTIVE      = 480,
   parameter int V_FP          = 10,
   parameter int V_SYNC        = 2,
   parameter int V_BP          = 33,
   parameter bit HS_POL        = 1'b0,
   parameter bit VS_POL        = 1'b0,
   parameter int COLOR_W       = 4,
   parameter int PADDLE_W      = 10,
   parameter int PADDLE_H      = 60,
   parameter int PADDLE_MARGIN = 20,
   parameter int BALL_SIZE     = 8,
   parameter logic [3*COLOR_W-1:0] BALL_RGB   = 12'hF00,
   parameter logic [3*COLOR_W-1:0] PADDLE_RGB = 12'hFFF,
   parameter logic [3*COLOR_W-1:0] NET_RGB    = 12'h888
) (
   input  logic               clk_100MHz,
   input  logic               reset,
   input  logic [9:0]         paddle0_pos,
   input  logic [9:0]         paddle1_pos,
   input  logic [9:0]         ball_pos_x,
   input  logic [9:0]         ball_pos_y,
   output logic               hsync_VGA,
   output logic               vsync_VGA,
   output logic [COLOR_W-1:0] red_VGA,
   output logic [COLOR_W-1:0] green_VGA,
   output logic [COLOR_W-1:0] blue_VGA,
   output logic               de,
   output logic               frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_LOAD  = 10'(V_ACTIVE);
   localparam logic [9:0]  P_MAX   = 10'(V_ACTIVE - PADDLE_H);
   localparam logic [9:0]  BX_MAX  = 10'(H_ACTIVE - BALL_SIZE);
   localparam logic [9:0]  BY_MAX  = 10'(V_ACTIVE - BALL_SIZE);
   localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] LP_BEG  = 11'(PADDLE_MARGIN);
   localparam logic [10:0] RP_BEG  = 11'(H_ACTIVE - PADDLE_MARGIN - PADDLE_W);
   localparam logic [10:0] PAD_W   = 11'(PADDLE_W);
   localparam logic [10:0] PAD_H   = 11'(PADDLE_H);
   localparam logic [10:0] BALL_SZ = 11'(BALL_SIZE);
   localparam logic [10:0] NET_L   = 11'(H_ACTIVE / 2 - 1);
   localparam logic [10:0] NET_R   = 11'(H_ACTIVE / 2);

   // Clamp a position so the object stays fully on screen.
   function automatic logic [9:0] sat_pos(input logic [9:0] pos, input logic [9:0] lim);
      return (pos > lim) ? lim : pos;
   endfunction

   // True when v lies in [beg, beg+len-1]; 11-bit so beg+len cannot wrap.
   function automatic logic in_span(input logic [10:0] v, input logic [10:0] beg,
                                    input logic [10:0] len);
      return (v >= beg) && (v < beg + len);
   endfunction

   logic [DIV_W-1:0]     div_cnt;
   logic                 pix_en;
   logic [9:0]           sx, sy;
   logic [9:0]           p0, p1, bx, by;
   logic [10:0]          x, y;
   logic                 load;
   logic                 active_p0, hs_act_p0, vs_act_p0;
   logic                 ball_hit, lp_hit, rp_hit, net_hit;
   logic [3*COLOR_W-1:0] rgb_p0;

   assign pix_en = (div_cnt == DIV_LAST);
   assign x      = {1'b0, sx};
   assign y      = {1'b0, sy};
   assign load   = pix_en && (sx == 10'd0) && (sy == V_LOAD);

   // Pixel-rate divider; reset restarts its phase.
   always_ff @(posedge clk_100MHz) begin
      if (reset)       div_cnt <= '0;
      else if (pix_en) div_cnt <= '0;
      else             div_cnt <= div_cnt + DIV_W'(1);
   end

   // Raster counters advance once per pixel.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         sx <= '0;
         sy <= '0;
      end else if (pix_en) begin
         if (sx == H_LAST) begin
            sx <= '0;
            sy <= (sy == V_LAST) ? 10'd0 : sy + 10'd1;
         end else begin
            sx <= sx + 10'd1;
         end
      end
   end

   // Shadow positions load at the start of vertical blanking; frame_tick marks it.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         p0         <= '0;
         p1         <= '0;
         bx         <= '0;
         by         <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= load;
         if (load) begin
            p0 <= sat_pos(paddle0_pos, P_MAX);
            p1 <= sat_pos(paddle1_pos, P_MAX);
            bx <= sat_pos(ball_pos_x, BX_MAX);
            by <= sat_pos(ball_pos_y, BY_MAX);
         end
      end
   end

   // Stage p0: timing decode and object hit tests on the current raster position.
   always_comb begin
      active_p0 = (x < H_ACT) && (y < V_ACT);
      hs_act_p0 = (x >= HS_BEG) && (x < HS_END);
      vs_act_p0 = (y >= VS_BEG) && (y < VS_END);
      ball_hit  = in_span(x, {1'b0, bx}, BALL_SZ) && in_span(y, {1'b0, by}, BALL_SZ);
      lp_hit    = in_span(x, LP_BEG, PAD_W) && in_span(y, {1'b0, p0}, PAD_H);
      rp_hit    = in_span(x, RP_BEG, PAD_W) && in_span(y, {1'b0, p1}, PAD_H);
      net_hit   = ((x == NET_L) || (x == NET_R)) && !sy[4];
   end

   // Colour priority: ball over paddles over net; blank outside the active area.
   always_comb begin
      rgb_p0 = '0;
      if (active_p0) begin
         if (ball_hit)                rgb_p0 = BALL_RGB;
         else if (lp_hit || rp_hit)   rgb_p0 = PADDLE_RGB;
         else if (net_hit)            rgb_p0 = NET_RGB;
      end
   end

   // Stage p1: output register, updated once per pixel and held in between.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         hsync_VGA <= ~HS_POL;
         vsync_VGA <= ~VS_POL;
         de        <= 1'b0;
         red_VGA   <= '0;
         green_VGA <= '0;
         blue_VGA  <= '0;
      end else if (pix_en) begin
         hsync_VGA <= hs_act_p0 ? HS_POL : ~HS_POL;
         vsync_VGA <= vs_act_p0 ? VS_POL : ~VS_POL;
         de        <= active_p0;
         {red_VGA, green_VGA, blue_VGA} <= rgb_p0;
      end
   end

endmodule

// File: tb/tb_pong_vga_engine.sv
// Bench for pong_vga_engine on a reduced raster (64x40 total, 48x32 visible).
// A per-clock reference model queues the expected output for each pixel and
// checks it against the registered outputs; directed steps cover reset, divider
// phase, frame-coherent update, clamping, priority and mid-frame reset.
module tb_pong_vga_engine;

   localparam int CLK_DIV  = 4;
   localparam int H_ACTIVE = 48, H_FP = 4, H_SYNC = 8, H_BP = 4;
   localparam int V_ACTIVE = 32, V_FP = 2, V_SYNC = 2, V_BP = 4;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int PADDLE_W = 4, PADDLE_H = 8, PADDLE_MARGIN = 4, BALL_SIZE = 4;
   localparam int FRAME_CLKS = H_TOTAL * V_TOTAL * CLK_DIV;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [11:0] rgb;
   } pix_t;

   logic       clk_100MHz = 1'b0;
   logic       reset;
   logic [9:0] paddle0_pos, paddle1_pos, ball_pos_x, ball_pos_y;
   logic       hsync_VGA, vsync_VGA, de, frame_tick;
   logic [3:0] red_VGA, green_VGA, blue_VGA;

   int   vectors = 0;
   int   miscompares = 0;

   int   m_div, m_sx, m_sy, m_p0, m_p1, m_bx, m_by;
   int   last_x, last_y;
   bit   upd, m_ft;
   pix_t q[$];
   pix_t cur;

   bit   prev_hs, prev_vs, line_ok, frame_ok, hs_ok, vs_ok;
   int   line_pix, frame_pix, hs_run, vs_run;

   pong_vga_engine #(
      .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4),
      .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H), .PADDLE_MARGIN(PADDLE_MARGIN),
      .BALL_SIZE(BALL_SIZE), .BALL_RGB(12'hF00), .PADDLE_RGB(12'hFFF), .NET_RGB(12'h888)
   ) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .paddle0_pos(paddle0_pos),
      .paddle1_pos(paddle1_pos),
      .ball_pos_x (ball_pos_x),
      .ball_pos_y (ball_pos_y),
      .hsync_VGA  (hsync_VGA),
      .vsync_VGA  (vsync_VGA),
      .red_VGA    (red_VGA),
      .green_VGA  (green_VGA),
      .blue_VGA   (blue_VGA),
      .de         (de),
      .frame_tick (frame_tick)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Expected output for raster position (x,y) with the current model shadows.
   function automatic pix_t render(input int x, input int y);
      pix_t p;
      p.hs  = (x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC) ? 1'b0 : 1'b1;
      p.vs  = (y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC) ? 1'b0 : 1'b1;
      p.de  = (x < H_ACTIVE) && (y < V_ACTIVE);
      p.rgb = 12'h000;
      if (p.de) begin
         if (x >= m_bx && x < m_bx + BALL_SIZE && y >= m_by && y < m_by + BALL_SIZE)
            p.rgb = 12'hF00;
         else if (x >= PADDLE_MARGIN && x < PADDLE_MARGIN + PADDLE_W &&
                  y >= m_p0 && y < m_p0 + PADDLE_H)
            p.rgb = 12'hFFF;
         else if (x >= H_ACTIVE - PADDLE_MARGIN - PADDLE_W && x < H_ACTIVE - PADDLE_MARGIN &&
                  y >= m_p1 && y < m_p1 + PADDLE_H)
            p.rgb = 12'hFFF;
         else if ((x == H_ACTIVE / 2 - 1 || x == H_ACTIVE / 2) && (y & 16) == 0)
            p.rgb = 12'h888;
      end
      return p;
   endfunction

   function automatic int clamp(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   // Sync shape measured from the DUT outputs at each pixel update.
   task automatic update_stats();
      line_pix++;
      frame_pix++;
      if (prev_hs && !hsync_VGA) begin
         chk("hs_fall_x", last_x, H_ACTIVE + H_FP);
         if (line_ok) chk("line_len", line_pix, H_TOTAL);
         line_pix = 0; line_ok = 1; hs_run = 0; hs_ok = 1;
      end
      if (!hsync_VGA) hs_run++;
      if (!prev_hs && hsync_VGA && hs_ok) chk("hs_width", hs_run, H_SYNC);
      if (prev_vs && !vsync_VGA) begin
         chk("vs_fall_y", last_y, V_ACTIVE + V_FP);
         chk("vs_fall_x", last_x, 0);
         if (frame_ok) chk("frame_len", frame_pix, H_TOTAL * V_TOTAL);
         frame_pix = 0; frame_ok = 1; vs_run = 0; vs_ok = 1;
      end
      if (!vsync_VGA) vs_run++;
      if (!prev_vs && vsync_VGA && vs_ok) chk("vs_width", vs_run, V_SYNC * H_TOTAL);
      prev_hs = hsync_VGA;
      prev_vs = vsync_VGA;
   endtask

   // One system clock: advance the model, then compare 1 time unit after the edge.
   task automatic tick();
      @(posedge clk_100MHz);
      upd  = 1'b0;
      m_ft = 1'b0;
      if (reset) begin
         m_div = 0; m_sx = 0; m_sy = 0;
         m_p0 = 0; m_p1 = 0; m_bx = 0; m_by = 0;
         q.delete();
         cur.hs = 1'b1; cur.vs = 1'b1; cur.de = 1'b0; cur.rgb = 12'h000;
         prev_hs = 1'b1; prev_vs = 1'b1;
         line_ok = 0; frame_ok = 0; hs_ok = 0; vs_ok = 0;
      end else if (m_div == CLK_DIV - 1) begin
         q.push_back(render(m_sx, m_sy));
         last_x = m_sx;
         last_y = m_sy;
         upd    = 1'b1;
         if (m_sx == 0 && m_sy == V_ACTIVE) begin
            m_p0 = clamp(int'(paddle0_pos), V_ACTIVE - PADDLE_H);
            m_p1 = clamp(int'(paddle1_pos), V_ACTIVE - PADDLE_H);
            m_bx = clamp(int'(ball_pos_x), H_ACTIVE - BALL_SIZE);
            m_by = clamp(int'(ball_pos_y), V_ACTIVE - BALL_SIZE);
            m_ft = 1'b1;
         end
         if (m_sx == H_TOTAL - 1) begin
            m_sx = 0;
            m_sy = (m_sy == V_TOTAL - 1) ? 0 : m_sy + 1;
         end else begin
            m_sx++;
         end
         m_div = 0;
      end else begin
         m_div++;
      end
      #1;
      if (upd) cur = q.pop_front();
      chk("hsync", hsync_VGA, cur.hs);
      chk("vsync", vsync_VGA, cur.vs);
      chk("de", de, cur.de);
      chk("rgb", {red_VGA, green_VGA, blue_VGA}, cur.rgb);
      chk("frame_tick", frame_tick, m_ft);
      if (upd) update_stats();
   endtask

   task automatic wait_pix(input int x, input int y);
      int  budget;
      bit  found;
      budget = 3 * FRAME_CLKS;
      found  = 1'b0;
      while (!found && budget > 0) begin
         tick();
         budget--;
         found = upd && last_x == x && last_y == y;
      end
      vectors++;
      assert (found) else begin
         miscompares++;
         $error("FAIL wait_pix(%0d,%0d): observed timeout, expected pixel update", x, y);
      end
   endtask

   task automatic wait_frame();
      int  budget;
      bit  found;
      budget = 2 * FRAME_CLKS;
      found  = 1'b0;
      while (!found && budget > 0) begin
         tick();
         budget--;
         found = m_ft;
      end
      vectors++;
      assert (found) else begin
         miscompares++;
         $error("FAIL wait_frame: observed timeout, expected frame_tick");
      end
   endtask

   task automatic check_pix(input string tag, input int x, input int y, input logic [11:0] exp);
      wait_pix(x, y);
      chk(tag, {red_VGA, green_VGA, blue_VGA}, exp);
   endtask

   initial begin
      reset = 1'b1;
      paddle0_pos = 10'd0; paddle1_pos = 10'd0; ball_pos_x = 10'd0; ball_pos_y = 10'd0;
      repeat (3) tick();
      chk("rst_de", de, 1'b0);
      chk("rst_rgb", {red_VGA, green_VGA, blue_VGA}, 12'h000);
      chk("rst_hsync", hsync_VGA, 1'b1);
      chk("rst_vsync", vsync_VGA, 1'b1);
      chk("rst_frame_tick", frame_tick, 1'b0);

      // First update lands on the 4th clk after release: pixel (0,0), ball at origin.
      reset = 1'b0;
      repeat (3) begin
         tick();
         chk("pre_update_de", de, 1'b0);
      end
      tick();
      chk("first_update_de", de, 1'b1);
      chk("first_update_rgb", {red_VGA, green_VGA, blue_VGA}, 12'hF00);

      // Frame-coherent update: ball_x changes mid-frame, takes effect next frame.
      paddle0_pos = 10'd5; paddle1_pos = 10'd10; ball_pos_x = 10'd10; ball_pos_y = 10'd20;
      wait_frame();
      check_pix("f1_left_paddle", 4, 5, 12'hFFF);
      check_pix("f1_right_paddle", 40, 10, 12'hFFF);
      wait_pix(0, 12);
      ball_pos_x = 10'd20;
      check_pix("f1_left_of_ball", 9, 20, 12'h000);
      check_pix("f1_ball_old_l", 10, 20, 12'hF00);
      check_pix("f1_ball_old_r", 13, 23, 12'hF00);
      check_pix("f1_no_ball_new", 20, 23, 12'h000);
      wait_frame();
      check_pix("f2_ball_gone", 10, 20, 12'h000);
      check_pix("f2_ball_new_l", 20, 20, 12'hF00);
      check_pix("f2_ball_new_r", 23, 23, 12'hF00);
      check_pix("f2_right_of_ball", 24, 23, 12'h000);

      // Clamping of out-of-range positions.
      paddle0_pos = 10'd1000; ball_pos_x = 10'd1023;
      wait_frame();
      check_pix("clamp_before_ball", 43, 20, 12'h000);
      check_pix("clamp_ball_l", 44, 20, 12'hF00);
      check_pix("clamp_ball_r", 47, 23, 12'hF00);
      check_pix("clamp_above_paddle", 4, 23, 12'h000);
      check_pix("clamp_paddle_top", 4, 24, 12'hFFF);
      check_pix("clamp_paddle_bot", 7, 31, 12'hFFF);

      // Priority: ball overlapping the left paddle, plus net dashes and blanking.
      paddle0_pos = 10'd5; ball_pos_x = 10'd5; ball_pos_y = 10'd5;
      wait_frame();
      check_pix("net_on", 23, 0, 12'h888);
      check_pix("paddle_only", 4, 5, 12'hFFF);
      check_pix("overlap_tl", 5, 5, 12'hF00);
      check_pix("overlap_br", 7, 8, 12'hF00);
      check_pix("ball_only", 8, 8, 12'hF00);
      check_pix("paddle_below_ball", 5, 9, 12'hFFF);
      check_pix("right_paddle_top", 40, 10, 12'hFFF);
      check_pix("net_on_r", 24, 15, 12'h888);
      check_pix("net_off", 23, 16, 12'h000);
      check_pix("right_paddle_bot", 43, 17, 12'hFFF);
      check_pix("right_of_paddle", 44, 17, 12'h000);
      check_pix("blank_net_row", 23, 32, 12'h000);
      chk("blank_de", de, 1'b0);

      // Mid-frame reset: one clk of reset, then counting restarts from (0,0).
      wait_frame();
      wait_pix(0, 20);
      tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_de", de, 1'b0);
      chk("mid_rst_rgb", {red_VGA, green_VGA, blue_VGA}, 12'h000);
      chk("mid_rst_hsync", hsync_VGA, 1'b1);
      chk("mid_rst_vsync", vsync_VGA, 1'b1);
      chk("mid_rst_frame_tick", frame_tick, 1'b0);
      reset = 1'b0;
      repeat (3) tick();
      chk("post_rst_pre_de", de, 1'b0);
      tick();
      chk("post_rst_first_de", de, 1'b1);
      chk("post_rst_first_rgb", {red_VGA, green_VGA, blue_VGA}, 12'hF00);
      wait_pix(0, V_ACTIVE + V_FP);
      chk("post_rst_vsync_low", vsync_VGA, 1'b0);
      wait_pix(0, V_ACTIVE + V_FP + V_SYNC);
      chk("post_rst_vsync_high", vsync_VGA, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
